// File: rtl/incdec_pkg.sv
// Shared encodings for the byte-serial increment/decrement unit:
// FSM states, op select and flag bit positions.
package incdec_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_INC = 1'b1;
    localparam logic OP_DEC = 1'b0;

    localparam int FLAG_S  = 3;
    localparam int FLAG_Z  = 2;
    localparam int FLAG_AC = 1;
    localparam int FLAG_P  = 0;

endpackage

// File: rtl/incdec_slice.sv
// One byte slice of the incrementer/decrementer: oR = iA +/- iCin,
// oCout is the carry (inc) or borrow (dec) out of the slice.
module incdec_slice
    import incdec_pkg::*;
#(
    parameter int DATASIZE = 8
) (
    input  logic                incdec_op,
    input  logic [DATASIZE-1:0] iA,
    input  logic                iCin,
    output logic [DATASIZE-1:0] oR,
    output logic                oCout
);

    logic [DATASIZE:0] sum;

    // The extra top bit of the widened sum/difference is the carry or borrow.
    always_comb begin
        if (incdec_op == OP_INC) begin
            sum = {1'b0, iA} + {{DATASIZE{1'b0}}, iCin};
        end else begin
            sum = {1'b0, iA} - {{DATASIZE{1'b0}}, iCin};
        end
        oR    = sum[DATASIZE-1:0];
        oCout = sum[DATASIZE];
    end

endmodule

// File: rtl/incdec_seq.sv
// Byte-serial INR/DCR/INX/DCX unit: walks one slice up from the low byte
// and stops as soon as no carry/borrow remains.
module incdec_seq
    import incdec_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int NBYTES   = 2
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic                       iStart,
    input  logic                       incdec_op,
    input  logic                       iWide,
    input  logic [NBYTES*DATASIZE-1:0] iA,
    output logic [NBYTES*DATASIZE-1:0] oR,
    output logic                       oBusy,
    output logic                       oDone,
    output logic [3:0]                 oFlags,
    output logic                       oK
);

    localparam int W  = NBYTES * DATASIZE;
    localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NBYTES - 1);

    logic [1:0]          state_p1;
    logic [W-1:0]        opr_p1;
    logic [KW-1:0]       idx_p1;
    logic                cy_p1;
    logic                op_p1;
    logic                wide_p1;
    logic [3:0]          flags_p1;
    logic                k_p1;

    logic [DATASIZE-1:0] cur_byte;
    logic [DATASIZE-1:0] new_byte;
    logic                cout;
    logic                is_last;
    logic                finish;

    function automatic logic [3:0] narrow_flags(input logic op,
                                                input logic [DATASIZE-1:0] a,
                                                input logic [DATASIZE-1:0] r);
        logic [3:0] f;
        f[FLAG_S]  = r[DATASIZE-1];
        f[FLAG_Z]  = (r == '0);
        f[FLAG_AC] = (op == OP_INC) ? (a[3:0] == 4'hF) : (a[3:0] != 4'h0);
        f[FLAG_P]  = ~^r;
        return f;
    endfunction

    // Select the byte currently being stepped; unprocessed bytes stay as latched.
    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_p1 == i[KW-1:0]) begin
                cur_byte = opr_p1[i*DATASIZE +: DATASIZE];
            end
        end
    end

    incdec_slice #(
        .DATASIZE(DATASIZE)
    ) u_slice (
        .incdec_op(op_p1),
        .iA       (cur_byte),
        .iCin     (cy_p1),
        .oR       (new_byte),
        .oCout    (cout)
    );

    assign is_last = !wide_p1 || (idx_p1 == LAST_K);
    assign finish  = !cout || is_last;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_p1 <= ST_IDLE;
            opr_p1   <= '0;
            idx_p1   <= '0;
            cy_p1    <= 1'b0;
            op_p1    <= OP_DEC;
            wide_p1  <= 1'b0;
            flags_p1 <= '0;
            k_p1     <= 1'b0;
        end else begin
            case (state_p1)
                ST_IDLE: begin
                    if (iStart) begin
                        opr_p1   <= iA;
                        op_p1    <= incdec_op;
                        wide_p1  <= iWide;
                        idx_p1   <= '0;
                        cy_p1    <= 1'b1;
                        state_p1 <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (idx_p1 == i[KW-1:0]) begin
                            opr_p1[i*DATASIZE +: DATASIZE] <= new_byte;
                        end
                    end
                    cy_p1  <= cout;
                    idx_p1 <= idx_p1 + 1'b1;
                    if (!wide_p1) begin
                        flags_p1 <= narrow_flags(op_p1, cur_byte, new_byte);
                    end else if (finish) begin
                        // Wrap only when the carry/borrow ripples out of the top byte.
                        k_p1 <= cout && is_last;
                    end
                    if (finish) begin
                        state_p1 <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_p1 <= ST_IDLE;
                end
                default: begin
                    state_p1 <= ST_IDLE;
                end
            endcase
        end
    end

    assign oR     = opr_p1;
    assign oBusy  = (state_p1 == ST_RUN);
    assign oDone  = (state_p1 == ST_DONE);
    assign oFlags = flags_p1;
    assign oK     = k_p1;

endmodule
